// File: rtl/fifo1_pkg.sv
// Shared constants and the per-cycle operation type for the single-clock FIFO.
package fifo1_pkg;

  localparam int DEFAULT_DSIZE = 8;
  localparam int DEFAULT_ASIZE = 7;
  localparam int DEPTH         = 2 ** DEFAULT_ASIZE;

  // What the FIFO actually does on a given edge, after full/empty gating
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Combine the accepted push and pop strobes into one operation code
  function automatic fifo_op_e decode_op(input logic do_push, input logic do_pop);
    fifo_op_e op;
    case ({do_pop, do_push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo1_mem.sv
// Word storage for fifo1: synchronous write port and a registered read port.
// The read register clears on reset so the popped-data output starts at zero;
// the array itself is never cleared.
module fifo1_mem
  import fifo1_pkg::*;
#(
  parameter int DSIZE = DEFAULT_DSIZE,
  parameter int ASIZE = DEFAULT_ASIZE
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [2**ASIZE];

  // Store the incoming word when the write is enabled
  always_ff @(posedge wclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Load the read register on an enabled read, hold it otherwise
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo1.sv
// Single-clock FIFO: pointers, occupancy count and flags around fifo1_mem.
// Flags decode only the registered count, so winc/rinc never reach them
// combinationally.
module fifo1
  import fifo1_pkg::*;
#(
  parameter int DSIZE = DEFAULT_DSIZE,
  parameter int ASIZE = DEFAULT_ASIZE
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
);

  localparam logic [ASIZE:0] FULL_COUNT = {1'b1, {ASIZE{1'b0}}};

  logic [ASIZE-1:0] wptr;
  logic [ASIZE-1:0] rptr;
  logic [ASIZE:0]   count;
  logic             do_push;
  logic             do_pop;
  fifo_op_e         op;

  assign wfull  = (count == FULL_COUNT);
  assign rempty = (count == '0);

  // Gate requests by the flags and by reset so nothing moves in a reset cycle
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (wrst_n) begin
      do_push = winc & ~wfull;
      do_pop  = rinc & ~rempty;
    end
    op = decode_op(do_push, do_pop);
  end

  // Advance pointers on accepted transfers and track occupancy
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo1_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .we    (do_push),
    .waddr (wptr),
    .wdata (wdata),
    .re    (do_pop),
    .raddr (rptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo1.sv
// Randomized and directed bench for fifo1 with a queue-based reference model
// feeding a scoreboard that a separate monitor drains.
module tb_fifo1;

  localparam int DEPTH = fifo1_pkg::DEPTH;

  logic       wclk;
  logic       wrst_n;
  logic [7:0] wdata;
  logic       winc;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;

  int vecCount  = 0;
  int missCount = 0;

  logic [7:0] modelQ[$];
  logic [7:0] sbQ[$];
  logic [7:0] heldData = 8'h00;

  fifo1 dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .wdata (wdata),
    .winc  (winc),
    .rinc  (rinc),
    .rdata (rdata),
    .wfull (wfull),
    .rempty(rempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Compare one value and report it
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests on the falling edge
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
    @(negedge wclk);
    winc  = w;
    rinc  = r;
    wdata = d;
  endtask

  // Reference model: FIFO as a queue; popped words go to the scoreboard
  always @(posedge wclk) begin
    if (!wrst_n) begin
      modelQ.delete();
      sbQ.push_back(8'h00);
    end else begin
      logic canPop;
      logic canPush;
      canPop  = rinc && (modelQ.size() > 0);
      canPush = winc && (modelQ.size() < DEPTH);
      if (canPop) sbQ.push_back(modelQ.pop_front());
      if (canPush) modelQ.push_back(wdata);
    end
  end

  // Monitor: new output words from the scoreboard, otherwise rdata must hold
  always @(negedge wclk) begin
    if (sbQ.size() > 0) begin
      heldData = sbQ.pop_front();
      checkOutput("rdata_pop", 32'(rdata), 32'(heldData));
    end else begin
      checkOutput("rdata_hold", 32'(rdata), 32'(heldData));
    end
    checkOutput("rempty", 32'(rempty), 32'(modelQ.size() == 0));
    checkOutput("wfull", 32'(wfull), 32'(modelQ.size() == DEPTH));
  end

  initial begin
    logic [7:0] d;
    int pushesLeft;
    int cyc;

    wrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;

    // Reset for 5 cycles, then an rinc pulse while empty
    repeat (5) @(negedge wclk);
    checkOutput("reset_rempty", 32'(rempty), 32'd1);
    checkOutput("reset_wfull", 32'(wfull), 32'd0);
    checkOutput("reset_rdata", 32'(rdata), 32'h00);
    wrst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("empty_pop_rdata", 32'(rdata), 32'h00);

    // Single word round trip
    applyStimulus(1'b1, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("a5_rdata", 32'(rdata), 32'hA5);
    checkOutput("a5_rempty", 32'(rempty), 32'd1);

    // Fill completely, try one overflow push, drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'(i));
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("fill_wfull", 32'(wfull), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("overflow_wfull", 32'(wfull), 32'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("drain_rdata", 32'(rdata), 32'd127);
    checkOutput("drain_rempty", 32'(rempty), 32'd1);

    // Push and pop together at full, then together at one word
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 8'hEE);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("both_full_wfull", 32'(wfull), 32'd0);
    checkOutput("both_full_rempty", 32'(rempty), 32'd0);
    for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h77);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("both_one_rempty", 32'(rempty), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("both_one_new_word", 32'(rdata), 32'h77);
    checkOutput("both_one_rempty_after", 32'(rempty), 32'd1);

    // Random pulsed pushes with quarter-rate pops, then drain
    pushesLeft = 125;
    cyc = 0;
    while (pushesLeft > 0) begin
      logic w;
      w = (cyc % 2 == 0);
      d = 8'($urandom);
      applyStimulus(w, (cyc % 4 == 3), d);
      if (w) pushesLeft--;
      cyc++;
    end
    cyc = 0;
    while (modelQ.size() > 0 && cyc < 400) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      cyc++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("random_drained", 32'(rempty), 32'd1);

    // Reset with 50 words stored and requests active in the reset cycle
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0, 8'($urandom));
    @(negedge wclk);
    wrst_n = 1'b0;
    winc   = 1'b1;
    rinc   = 1'b1;
    wdata  = 8'h99;
    @(negedge wclk);
    checkOutput("mid_reset_rempty", 32'(rempty), 32'd1);
    checkOutput("mid_reset_wfull", 32'(wfull), 32'd0);
    checkOutput("mid_reset_rdata", 32'(rdata), 32'h00);
    wrst_n = 1'b1;
    winc   = 1'b1;
    rinc   = 1'b0;
    wdata  = 8'h3C;
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("post_reset_rdata", 32'(rdata), 32'h3C);
    checkOutput("post_reset_rempty", 32'(rempty), 32'd1);

    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
